// File: rtl/pwm_output_stage_if.sv
// rtl/pwm_output_stage_if.sv - configuration and pin-drive bundle between the register block and the PWM output stage
interface pwm_output_stage_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );
endinterface

// File: rtl/pwm_output_stage.sv
// rtl/pwm_output_stage.sv - 16-pin output stage, each pin forced low, forced high or driven by a shared 8-bit PWM
module pwm_output_stage #(
    parameter int CLK_DIV = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_output_stage_if.slave    bus
);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] r_presc;
    logic [7:0]  r_pcnt;
    logic [7:0]  r_duty_sh;
    logic [15:0] r_out;
    logic        r_period_start;

    logic        w_tick;
    logic        w_wrap;
    logic        w_pwm_sig;
    logic [15:0] w_en_out;
    logic [15:0] w_en_pwm;
    logic [15:0] w_drive;

    assign w_tick    = (r_presc == DIV_LAST);
    assign w_wrap    = w_tick && (r_pcnt == 8'hFF);
    // Full-scale duty is a true 100%, not 255/256.
    assign w_pwm_sig = (r_duty_sh == 8'hFF) || (r_pcnt < r_duty_sh);

    assign w_en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign w_en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    assign w_drive  = w_en_out & (~w_en_pwm | {16{w_pwm_sig}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc        <= 16'd0;
            r_pcnt         <= 8'd0;
            r_duty_sh      <= 8'd0;
            r_out          <= 16'h0000;
            r_period_start <= 1'b0;
        end else begin
            r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
            if (w_tick) begin
                r_pcnt <= r_pcnt + 8'd1;
            end
            // Duty only changes at the wrap so a period is never truncated.
            if (w_wrap) begin
                r_duty_sh <= bus.pwm_duty_cycle;
            end
            r_out          <= w_drive;
            r_period_start <= w_wrap;
        end
    end

    assign bus.out          = r_out;
    assign bus.period_start = r_period_start;
endmodule

// File: tb/tb_pwm_output_stage.sv
// tb/tb_pwm_output_stage.sv - self-checking bench for pwm_output_stage at CLK_DIV 2 and 1
module tb_pwm_output_stage;
    localparam int DIV0 = 2;
    localparam int DIV1 = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_out = 16'h0000;
    logic [15:0] en_pwm = 16'h0000;
    logic [7:0]  duty = 8'd0;

    int checks = 0;
    int failures = 0;
    int fail_lines = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    pwm_output_stage_if bus0();
    pwm_output_stage_if bus1();

    assign bus0.en_reg_out_7_0  = en_out[7:0];
    assign bus0.en_reg_out_15_8 = en_out[15:8];
    assign bus0.en_reg_pwm_7_0  = en_pwm[7:0];
    assign bus0.en_reg_pwm_15_8 = en_pwm[15:8];
    assign bus0.pwm_duty_cycle  = duty;
    assign bus1.en_reg_out_7_0  = en_out[7:0];
    assign bus1.en_reg_out_15_8 = en_out[15:8];
    assign bus1.en_reg_pwm_7_0  = en_pwm[7:0];
    assign bus1.en_reg_pwm_15_8 = en_pwm[15:8];
    assign bus1.pwm_duty_cycle  = duty;

    pwm_output_stage #(.CLK_DIV(DIV0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    pwm_output_stage #(.CLK_DIV(DIV1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Model: everything derives from the number of clk edges since reset release.
    int          m_k[2]    = '{0, 0};
    logic [7:0]  m_duty[2] = '{8'd0, 8'd0};
    logic [15:0] m_out[2]  = '{16'h0, 16'h0};
    logic        m_ps[2]   = '{1'b0, 1'b0};

    function automatic int div_of(input int j);
        return (j == 0) ? DIV0 : DIV1;
    endfunction

    function automatic bit model_pwm(input int k, input int div, input logic [7:0] d);
        int count_in_period;
        count_in_period = (k / div) % 256;
        return (d == 8'd255) || (count_in_period < int'(d));
    endfunction

    function automatic bit is_boundary(input int k, input int div);
        return (k % (256 * div)) == 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
                m_k[j]    <= 0;
                m_duty[j] <= 8'd0;
                m_out[j]  <= 16'h0;
                m_ps[j]   <= 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                m_out[j] <= en_out & (~en_pwm | {16{model_pwm(m_k[j], div_of(j), m_duty[j])}});
                m_ps[j]  <= is_boundary(m_k[j] + 1, div_of(j));
                if (is_boundary(m_k[j] + 1, div_of(j))) begin
                    m_duty[j] <= duty;
                end
                m_k[j] <= m_k[j] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks <= checks + 2;
            if (bus0.out !== m_out[0] || bus0.period_start !== m_ps[0]) begin
                failures <= failures + 1;
                if (fail_lines < 30) begin
                    fail_lines <= fail_lines + 1;
                    $display("FAIL cycle_div2 t=%0t out=%h ps=%b expected out=%h ps=%b",
                             $time, bus0.out, bus0.period_start, m_out[0], m_ps[0]);
                end
            end
            if (bus1.out !== m_out[1] || bus1.period_start !== m_ps[1]) begin
                failures <= failures + 1;
                if (fail_lines < 30) begin
                    fail_lines <= fail_lines + 1;
                    $display("FAIL cycle_div1 t=%0t out=%h ps=%b expected out=%h ps=%b",
                             $time, bus1.out, bus1.period_start, m_out[1], m_ps[1]);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Counts negedges until dut0's next period_start, tracking out[0] high time.
    task automatic wait_ps(input int change_at, input logic [7:0] new_duty,
                           output int len, output int highs, output int ps1_at);
        len = 0;
        highs = 0;
        ps1_at = -1;
        while (1) begin
            @(negedge clk);
            len++;
            if (bus0.out[0]) highs++;
            if (bus1.period_start && ps1_at < 0) ps1_at = len;
            if (len == change_at) duty = new_duty;
            if (bus0.period_start) break;
            if (len >= 2000) begin
                checks++;
                failures++;
                $display("FAIL period_start_timeout waited=%0d required<=512", len);
                break;
            end
        end
    endtask

    int len, highs, ps1_at, guard;

    initial begin
        // Reset with random inputs
        en_out = 16'($urandom);
        en_pwm = 16'($urandom);
        duty   = 8'($urandom);
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out", int'(bus0.out), 0);
        chk("reset_ps", int'(bus0.period_start), 0);

        en_out = 16'h0; en_pwm = 16'h0; duty = 8'd0;
        #2 rst_n = 1'b1;
        repeat (600) @(negedge clk);
        chk("unconfigured_out", int'(bus0.out), 0);

        // Static drive
        en_out = 16'hA5F0;
        @(negedge clk);
        chk("static_a5f0", int'(bus0.out), 16'hA5F0);
        en_out = 16'h0000;
        @(negedge clk);
        chk("static_off", int'(bus0.out), 0);

        // Duty 128
        en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'd128;
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        chk("d128_len", len, 512);
        chk("d128_high", highs, 256);

        // Extremes, upper nibble statically high
        en_pwm = 16'h0FFF; duty = 8'd0;
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        chk("d0_high", highs, 0);
        chk("d0_static_pins", int'(bus0.out[15:12]), 15);
        duty = 8'd255;
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        chk("d255_high", highs, 512);
        chk("d255_static_pins", int'(bus0.out[15:12]), 15);

        // Mid-period update at pcnt = 100
        en_pwm = 16'hFFFF; duty = 8'd64;
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        wait_ps(200, 8'd192, len, highs, ps1_at);
        chk("mid_cur_len", len, 512);
        chk("mid_cur_high", highs, 128);
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        chk("mid_next_len", len, 512);
        chk("mid_next_high", highs, 384);

        // Reset in the middle of a high pulse
        duty = 8'd200;
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        guard = 0;
        while (!bus0.out[0] && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("pre_reset_high", int'(bus0.out[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out", int'(bus0.out), 0);
        chk("async_reset_ps", int'(bus0.period_start), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        chk("post_reset_first_len", len, 512);
        chk("post_reset_first_high", highs, 0);
        chk("div1_first_ps", ps1_at, 256);
        wait_ps(-1, 8'd0, len, highs, ps1_at);
        chk("post_reset_d200_len", len, 512);
        chk("post_reset_d200_high", highs, 400);

        cmp_en = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
